conv2d_relu_3x3: RTL and testbench

//  Single-window 3x3 signed convolution followed by ReLU. Computes the dot product of a
//  3x3 feature-map window with a 3x3 kernel, clamps negatives to zero and saturates the

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_relu_stage.sv | 31 +++
 rtl/conv2d_relu_3x3.sv | 92 +++++++++
 tb/tb_conv2d_relu_3x3.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths and the ReLU + saturation rule for the 3x3 convolution datapath.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;
  localparam int ACC_W  = 2 * DATA_W + 4;
  localparam int KSIZE  = 3;
  localparam int NTAPS  = KSIZE * KSIZE;

  // Negative sums clamp to zero, large positives clip to the top of the signed output range.
  function automatic int relu_sat(input int sum, input int out_w);
    int sat_max;
    sat_max = (1 << (out_w - 1)) - 1;
    if (sum < 0)
      return 0;
    else if (sum > sat_max)
      return sat_max;
    else
      return sum;
  endfunction

endpackage

// File: rtl/conv_relu_stage.sv
// Combinational row-wise adder tree over the nine products, followed by ReLU and saturation.
module conv_relu_stage
  import conv_pkg::*;
#(
  parameter int PROD_W = 2 * conv_pkg::DATA_W,
  parameter int SUM_W  = conv_pkg::ACC_W,
  parameter int RES_W  = conv_pkg::OUT_W
) (
  input  logic [NTAPS-1:0][PROD_W-1:0] prods,
  output logic [RES_W-1:0]             result
);

  logic signed [SUM_W-1:0] row_sum [KSIZE];
  logic signed [SUM_W-1:0] total;

  // Four guard bits over the product width keep the nine-way sum exact.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      row_sum[r] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        row_sum[r] = row_sum[r] + SUM_W'($signed(prods[r*KSIZE + c]));
      end
    end
    total = '0;
    for (int r = 0; r < KSIZE; r++) begin
      total = total + row_sum[r];
    end
    result = RES_W'(relu_sat(int'(total), RES_W));
  end

endmodule

// File: rtl/conv2d_relu_3x3.sv
// Two-stage pipelined 3x3 signed convolution with ReLU: multipliers, then sum/clamp.
module conv2d_relu_3x3
  import conv_pkg::*;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int OUT_W  = conv_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_feature_map_00,
  input  logic signed [DATA_W-1:0] input_feature_map_01,
  input  logic signed [DATA_W-1:0] input_feature_map_02,
  input  logic signed [DATA_W-1:0] input_feature_map_10,
  input  logic signed [DATA_W-1:0] input_feature_map_11,
  input  logic signed [DATA_W-1:0] input_feature_map_12,
  input  logic signed [DATA_W-1:0] input_feature_map_20,
  input  logic signed [DATA_W-1:0] input_feature_map_21,
  input  logic signed [DATA_W-1:0] input_feature_map_22,
  input  logic signed [DATA_W-1:0] kernel_00,
  input  logic signed [DATA_W-1:0] kernel_01,
  input  logic signed [DATA_W-1:0] kernel_02,
  input  logic signed [DATA_W-1:0] kernel_10,
  input  logic signed [DATA_W-1:0] kernel_11,
  input  logic signed [DATA_W-1:0] kernel_12,
  input  logic signed [DATA_W-1:0] kernel_20,
  input  logic signed [DATA_W-1:0] kernel_21,
  input  logic signed [DATA_W-1:0] kernel_22,
  output logic        [OUT_W-1:0]  output_feature_map
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 4;

  logic [NTAPS-1:0][DATA_W-1:0] win;
  logic [NTAPS-1:0][DATA_W-1:0] ker;
  logic [NTAPS-1:0][PROD_W-1:0] prod_d;
  logic [NTAPS-1:0][PROD_W-1:0] prod_q;
  logic [OUT_W-1:0]             result_d;

  // Row-major flattening: tap index = row*3 + col.
  assign win[0] = input_feature_map_00;
  assign win[1] = input_feature_map_01;
  assign win[2] = input_feature_map_02;
  assign win[3] = input_feature_map_10;
  assign win[4] = input_feature_map_11;
  assign win[5] = input_feature_map_12;
  assign win[6] = input_feature_map_20;
  assign win[7] = input_feature_map_21;
  assign win[8] = input_feature_map_22;

  assign ker[0] = kernel_00;
  assign ker[1] = kernel_01;
  assign ker[2] = kernel_02;
  assign ker[3] = kernel_10;
  assign ker[4] = kernel_11;
  assign ker[5] = kernel_12;
  assign ker[6] = kernel_20;
  assign ker[7] = kernel_21;
  assign ker[8] = kernel_22;

  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      prod_d[i] = PROD_W'($signed(win[i]) * $signed(ker[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  conv_relu_stage #(
    .PROD_W (PROD_W),
    .SUM_W  (SUM_W),
    .RES_W  (OUT_W)
  ) u_stage (
    .prods  (prod_q),
    .result (result_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      output_feature_map <= '0;
    end else begin
      output_feature_map <= result_d;
    end
  end

endmodule

// File: tb/tb_conv2d_relu_3x3.sv
// Randomized and directed bench for conv2d_relu_3x3 against a value-level pipeline model.
module tb_conv2d_relu_3x3;

  logic              clk;
  logic              reset;
  logic signed [7:0] win [9];
  logic signed [7:0] ker [9];
  logic [15:0]       output_feature_map;

  int n_tests;
  int n_fail;
  int exp_s1;
  int exp_s2;

  conv2d_relu_3x3 dut (
    .clk                  (clk),
    .reset                (reset),
    .input_feature_map_00 (win[0]),
    .input_feature_map_01 (win[1]),
    .input_feature_map_02 (win[2]),
    .input_feature_map_10 (win[3]),
    .input_feature_map_11 (win[4]),
    .input_feature_map_12 (win[5]),
    .input_feature_map_20 (win[6]),
    .input_feature_map_21 (win[7]),
    .input_feature_map_22 (win[8]),
    .kernel_00            (ker[0]),
    .kernel_01            (ker[1]),
    .kernel_02            (ker[2]),
    .kernel_10            (ker[3]),
    .kernel_11            (ker[4]),
    .kernel_12            (ker[5]),
    .kernel_20            (ker[6]),
    .kernel_21            (ker[7]),
    .kernel_22            (ker[8]),
    .output_feature_map   (output_feature_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_conv();
    int sum;
    sum = 0;
    for (int i = 0; i < 9; i++) sum += int'(win[i]) * int'(ker[i]);
    if (sum < 0) return 0;
    if (sum > 32767) return 32767;
    return sum;
  endfunction

  // One clock: advance the model with what the DUT samples, then compare just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) begin
      exp_s1 = 0;
      exp_s2 = 0;
    end else begin
      exp_s2 = exp_s1;
      exp_s1 = ref_conv();
    end
    #1;
    chk(tag, int'(output_feature_map), exp_s2);
  endtask

  task automatic set_case(input int id);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        case (id)
          1: begin win[r*3+c] = 8'(r*3 + c + 1); ker[r*3+c] = 8'(1 - c); end
          2: begin win[r*3+c] = 8'(r*3 + c + 1); ker[r*3+c] = 8'(c - 1); end
          3: begin win[r*3+c] = -8'sd128; ker[r*3+c] = -8'sd128; end
          4: begin win[r*3+c] = 8'sd127;  ker[r*3+c] = -8'sd128; end
          default: begin win[r*3+c] = 8'sd127; ker[r*3+c] = 8'sd1; end
        endcase
      end
    end
  endtask

  function automatic logic signed [7:0] rand_elem();
    case ($urandom_range(0, 5))
      0: return -8'sd128;
      1: return 8'sd127;
      2: return 8'sd0;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_s1  = 0;
    exp_s2  = 0;
    reset   = 1'b0;
    set_case(3);
    step("reset_hold0");
    step("reset_hold1");
    chk("reset_out", int'(output_feature_map), 0);

    // Release: the first two outputs still come from reset-cleared stages.
    reset = 1'b1;
    set_case(2);
    step("fill0");
    chk("fill0_zero", int'(output_feature_map), 0);
    step("fill1");
    chk("case2_six", int'(output_feature_map), 6);

    set_case(1);
    step("c1_a");
    step("c1_b");
    chk("case1_neg6_zero", int'(output_feature_map), 0);

    set_case(3);
    step("c3_a");
    step("c3_b");
    chk("case3_sat", int'(output_feature_map), 32767);

    set_case(4);
    step("c4a_a");
    step("c4a_b");
    chk("case4a_neg_zero", int'(output_feature_map), 0);

    set_case(5);
    step("c4b_a");
    step("c4b_b");
    chk("case4b_1143", int'(output_feature_map), 1143);

    // Back-to-back windows, one per clock.
    set_case(2);
    step("b2b_0");
    set_case(5);
    step("b2b_1");
    chk("b2b_six", int'(output_feature_map), 6);
    set_case(1);
    step("b2b_2");
    chk("b2b_1143", int'(output_feature_map), 1143);
    step("b2b_3");
    chk("b2b_zero", int'(output_feature_map), 0);

    // Single-cycle reset mid-stream.
    set_case(2);
    step("pre_rst");
    reset = 1'b0;
    step("mid_rst");
    chk("mid_rst_zero", int'(output_feature_map), 0);
    reset = 1'b1;
    step("post_rst0");
    chk("post_rst0_zero", int'(output_feature_map), 0);
    step("post_rst1");
    chk("post_rst1_six", int'(output_feature_map), 6);

    // Random windows with rare resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 9; i++) begin
        win[i] = rand_elem();
        ker[i] = rand_elem();
      end
      reset = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
      step("random");
    end
    reset = 1'b1;
    step("drain0");
    step("drain1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
